palette_engine: RTL
===================

Name: palette_engine

Overview:
- Runtime-programmable colour palette for the sprite/background render path; generalises the fixed 16-entry ROM palettes to a parametrised, double-buffered register palette.
- Provides N_CH independent pipelined lookup channels, so background and sprite layers resolve in parallel.
- Adds a frame-synchronous bank commit and a global brightness fade for level transitions and death/exit screens.
- Sits between the sprite/tile index generators and the VGA colour mux.

Parameters:
- IDX_W, 4, index width; palette depth = 2**IDX_W entries.
- COLOR_W, 4, bits per colour channel; entry width = 3*COLOR_W as {R,G,B}.
- N_CH, 2, number of parallel lookup channels.
- FADE_W, 4, fade resolution; level range 0..2**FADE_W.
- FADE_RATE, 2, frames per fade step (>=1).

Ports:
- Clk, input, 1, system clock.
- Reset_n, input, 1, asynchronous active-low reset.
- frame_start, input, 1, one-cycle pulse at the start of vertical blank.
- wr_en, input, 1, write a shadow-bank entry.
- wr_addr, input, IDX_W, shadow entry address.
- wr_data, input, 3*COLOR_W, {R,G,B} value to write.
- swap_req, input, 1, pulse requesting a shadow-to-active commit at the next frame_start.
- swap_pending, output, 1, commit requested and not yet performed.
- fade_target, input, FADE_W+1, requested brightness level.
- fade_level, output, FADE_W+1, current brightness level.
- fade_busy, output, 1, fade_level != clamped fade_target.
- idx_valid, input, N_CH, per-channel lookup valid.
- idx, input, N_CH*IDX_W, per-channel index; channel c at [c*IDX_W +: IDX_W].
- rgb_valid, output, N_CH, per-channel result valid.
- rgb, output, N_CH*3*COLOR_W, per-channel colour; channel c at [c*3*COLOR_W +: 3*COLOR_W].

Behaviour:
- Reset (async, Reset_n=0):
  - Active and shadow entry i = {g,g,g}, where g = i zero-extended/truncated to COLOR_W (default parameters: entry 5 = 0x555).
  - rgb=0, rgb_valid=0, swap_pending=0, fade_level=2**FADE_W, fade_busy=0, frame counter=0, pipeline valids=0.
  - Reset mid-fade or mid-pipeline discards all state.
- Writes:
  - wr_en writes wr_data to shadow[wr_addr] at the clock edge.
  - Writes never touch the active bank directly.
- Commit:
  - swap_req sets swap_pending.
  - On a cycle with frame_start=1 and swap_pending=1 (including swap_req in that same cycle), all active entries are loaded from shadow in parallel in one cycle, and swap_pending clears.
  - Shadow is unchanged by a commit.
  - A write in the commit cycle lands in shadow only; active receives the pre-write shadow value.
  - swap_req while already pending has no further effect.
  - frame_start without a pending request leaves the banks unchanged.
- Fade:
  - tgt = min(fade_target, 2**FADE_W).
  - If fade_level == tgt: the frame counter holds 0 and fade_busy=0.
  - Otherwise each frame_start increments the counter. When the counter reaches FADE_RATE-1, fade_level moves 1 toward tgt and the counter clears.
  - A target change mid-fade continues from the current level with no restart; the counter keeps its value.
  - fade_busy is combinational from fade_level vs tgt.
- Lookup pipeline (per channel, independent), fixed 2-cycle latency, no stall, one lookup per channel per cycle:
  - S1 registers active[idx_c] and idx_valid_c.
  - S2 computes each channel value as out = (col * fade_level) >> FADE_W. This is a (COLOR_W+FADE_W+1)-bit product, truncated to COLOR_W, and is exact identity at level 2**FADE_W.
  - S2 uses fade_level as it stands in the S2 cycle.
  - rgb is registered.
  - When valid=0, rgb holds its previous value and rgb_valid=0.
  - A lookup issued in the cycle before a commit reads the old active value. A lookup issued in the commit cycle reads the old value; the next cycle reads the new one.
  - Multiple channels reading the same index is legal.

Test Plan:
- Reset, then idx ch0=5, ch1=15 valid at cycle t → at t+2: rgb ch0=0x555, ch1=0xFFF, rgb_valid=2'b11.
- Write shadow[3]=0xF80 with swap_req; lookup idx 3 → returns 0x333 until the cycle after frame_start; then 0xF80, and swap_pending falls on that edge.
- wr_en to addr 3 with 0x00F in the same cycle as the commit frame_start (shadow[3]=0xF80) → active[3]=0xF80, shadow[3]=0x00F; a second commit yields 0x00F.
- fade_target=0 from level 16 with FADE_RATE=2 → level drops 1 every 2 frame_starts, reaching 0 after 32 frame_starts, with fade_busy high throughout. At level 8, entry 0xFA4 reads 0x752.
- fade_target=31 → clamped to 16, fade_busy=0; retarget from 4 down to 10 mid-fade → level climbs back from its current value.
- Continuous back-to-back lookups on both channels for 20 cycles, with Reset_n asserted mid-stream → all outputs zero immediately, no stale valid after release.

Source files
------------

// File: rtl/palette_engine.sv
// Double-buffered, runtime-programmable colour palette with N_CH pipelined lookup channels,
// frame-synchronous shadow-to-active commit and a global brightness fade.
module palette_engine #(
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned COLOR_W   = 4,
  parameter int unsigned N_CH      = 2,
  parameter int unsigned FADE_W    = 4,
  parameter int unsigned FADE_RATE = 2
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        frame_start,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_addr,
  input  logic [3*COLOR_W-1:0]        wr_data,
  input  logic                        swap_req,
  output logic                        swap_pending,
  input  logic [FADE_W:0]             fade_target,
  output logic [FADE_W:0]             fade_level,
  output logic                        fade_busy,
  input  logic [N_CH-1:0]             idx_valid,
  input  logic [N_CH*IDX_W-1:0]       idx,
  output logic [N_CH-1:0]             rgb_valid,
  output logic [N_CH*3*COLOR_W-1:0]   rgb
);

  localparam int unsigned Depth = 2 ** IDX_W;
  localparam int unsigned EntW  = 3 * COLOR_W;
  localparam int unsigned LvlW  = FADE_W + 1;
  localparam int unsigned ProdW = COLOR_W + FADE_W + 1;
  localparam int unsigned CntW  = (FADE_RATE > 1) ? $clog2(FADE_RATE) : 1;

  localparam logic [LvlW-1:0] LvlMax  = LvlW'(2 ** FADE_W);
  localparam logic [CntW-1:0] CntLast = CntW'(FADE_RATE - 1);

  logic [EntW-1:0] shadow_q [Depth];
  logic [EntW-1:0] active_q [Depth];

  logic            swap_pending_q, swap_pending_d;
  logic            commit;
  logic [LvlW-1:0] level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [LvlW-1:0] tgt;

  logic [EntW-1:0] s1_col_q [N_CH];
  logic [N_CH-1:0] s1_vld_q;
  logic [EntW-1:0] scaled [N_CH];
  logic [N_CH*EntW-1:0] rgb_q;
  logic [N_CH-1:0] rgb_vld_q;

  // A request raised in the frame_start cycle itself commits immediately.
  assign commit = frame_start & (swap_pending_q | swap_req);

  always_comb begin
    swap_pending_d = swap_pending_q | swap_req;
    if (commit) begin
      swap_pending_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < Depth; i++) begin
        shadow_q[i] <= {3{COLOR_W'(i)}};
      end
    end else if (wr_en) begin
      shadow_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < Depth; i++) begin
        active_q[i] <= {3{COLOR_W'(i)}};
      end
    end else if (commit) begin
      for (int i = 0; i < Depth; i++) begin
        active_q[i] <= shadow_q[i];
      end
    end
  end

  always_comb begin
    tgt       = (fade_target > LvlMax) ? LvlMax : fade_target;
    fade_busy = (level_q != tgt);
    level_d   = level_q;
    cnt_d     = cnt_q;
    if (!fade_busy) begin
      cnt_d = '0;
    end else if (frame_start) begin
      if (cnt_q == CntLast) begin
        cnt_d   = '0;
        level_d = (tgt > level_q) ? level_q + LvlW'(1) : level_q - LvlW'(1);
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      swap_pending_q <= 1'b0;
      level_q        <= LvlMax;
      cnt_q          <= '0;
    end else begin
      swap_pending_q <= swap_pending_d;
      level_q        <= level_d;
      cnt_q          <= cnt_d;
    end
  end

  function automatic logic [COLOR_W-1:0] scale_ch(input logic [COLOR_W-1:0] col,
                                                  input logic [LvlW-1:0]    lvl);
    logic [ProdW-1:0] prod;
    prod = ProdW'(col) * ProdW'(lvl);
    return prod[FADE_W +: COLOR_W];
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int c = 0; c < N_CH; c++) begin
        s1_col_q[c] <= '0;
      end
      s1_vld_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        s1_col_q[c] <= active_q[idx[c*IDX_W +: IDX_W]];
      end
      s1_vld_q <= idx_valid;
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      scaled[c] = '0;
      for (int k = 0; k < 3; k++) begin
        scaled[c][k*COLOR_W +: COLOR_W] = scale_ch(s1_col_q[c][k*COLOR_W +: COLOR_W], level_q);
      end
    end
  end

  // Invalid slots keep the last colour so the VGA mux never sees a spurious change.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q     <= '0;
      rgb_vld_q <= '0;
    end else begin
      rgb_vld_q <= s1_vld_q;
      for (int c = 0; c < N_CH; c++) begin
        if (s1_vld_q[c]) begin
          rgb_q[c*EntW +: EntW] <= scaled[c];
        end
      end
    end
  end

  assign swap_pending = swap_pending_q;
  assign fade_level   = level_q;
  assign rgb_valid    = rgb_vld_q;
  assign rgb          = rgb_q;

endmodule
